md_unit_sequencer: RTL and testbench
====================================

Name: md_unit_sequencer

Overview:
- Multi-cycle multiply/divide unit with HI/LO registers and its busy sequencer. It sits in the E stage beside the ALU.
- It accepts mult/multu/div/divu/mthi/mtlo from E and holds a busy window of fixed length.
- It raises a stall request to the hazard unit while any HI/LO-using instruction in D must wait.
- An exception/interrupt kill input suppresses issue from the E-stage victim instruction.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (legal range 1..15)
- DIV_CYCLES, 10, busy cycles for div/divu (legal range 1..15)

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high; clears all state
- start  input  1  E-stage instruction is an MD op, valid this cycle
- op  input  3  0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, others reserved (no-op)
- a  input  32  rs operand (forwarded)
- b  input  32  rt operand (forwarded)
- kill  input  1  E-stage instruction is being flushed (exception/eret/interrupt)
- d_uses_md  input  1  D-stage instruction is any MD op or mfhi/mflo
- busy  output  1  operation in progress
- stall_req  output  1  to hazard unit: freeze F/D, bubble E
- hi  output  32  HI register
- lo  output  32  LO register

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high; ports named clk and reset.
- Reset values: hi=0, lo=0, busy=0, internal counter=0, pending result=0, stall_req reflects only combinational inputs.
- Issue condition: issue = start & ~kill & ~busy & op valid.
- Issue of mult/multu/div/divu:
  - Compute the result from a and b in the issue cycle and latch it in pend_hi/pend_lo.
  - Load the counter with N = MULT_CYCLES or DIV_CYCLES.
  - busy=1 starting the cycle after issue.
- Counting: each busy cycle decrements the counter. On the edge where the counter goes 1->0: hi/lo <= pend, busy <= 0.
- Timing: issue in cycle t gives busy high in cycles t+1..t+N, and the new hi/lo are visible from cycle t+N+1.
- Arithmetic:
  - mult: signed 32x32 to 64, with hi = [63:32] and lo = [31:0].
  - multu: unsigned 32x32 to 64, same split.
  - div: signed, lo = quotient truncated toward zero, hi = remainder with the sign of the dividend.
  - divu: unsigned.
  - Divide by zero: busy window still runs; hi/lo are left unchanged at commit.
  - 0x80000000 / -1: lo=0x80000000, hi=0.
- mthi/mtlo: on issue, hi <= a (or lo <= a) at the next edge. No busy window.
- start while busy: ignored. The hazard unit guarantees this cannot happen because stall_req holds the instruction in D.
- kill with start in the same cycle: no issue, no hi/lo write.
- kill while busy: the running operation completes normally. The victim was already past E and is architecturally committed.
- stall_req = d_uses_md & (busy | (start & ~kill & op is mult/multu/div/divu)). This is combinational.
- Reset mid-operation: busy drops immediately, pending result is discarded, hi/lo=0.
- Reserved op values: no effect.

Decomposition:
- Shared definitions (the team's existing macro/define include): MD op encodings 0..5, funct codes for mult/multu/div/divu/mfhi/mflo/mthi/mtlo.
- One natural sub-module, md_compute: combinational 64-bit product/quotient/remainder and div-by-zero flag. The sequencer holds the counter, pend regs, hi/lo and stall logic.

Test Plan:
- mult a=0xFFFFFFFE (-2), b=3, then d_uses_md=1 -> stall_req high for cycles t..t+5; busy high t+1..t+5; from t+6 hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- multu a=0xFFFFFFFF, b=2 -> after 5 busy cycles hi=0x00000001, lo=0xFFFFFFFE.
- div a=-7 (0xFFFFFFF9), b=2 -> busy 10 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu with b=0 -> busy 10 cycles, hi/lo unchanged.
- mthi a=0x12345678 -> next cycle hi=0x12345678, busy=0. start mtlo with kill=1 -> lo unchanged.
- start=1 kill=1 op=mult -> busy stays 0, stall_req=0. kill asserted at busy cycle 2 of div -> result still committed after cycle 10.
- Assert reset during busy cycle 3 -> busy=0, hi=lo=0 immediately. A subsequent mult behaves normally.

Source files
------------

// File: rtl/md_unit_sequencer_pkg.sv
// Shared definitions for the multiply/divide unit: MD op encodings, MIPS funct
// codes for the HI/LO instructions, sequencer state and small op-class helpers.
package md_unit_sequencer_pkg;

    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5
    } md_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } md_state_e;

    localparam logic [5:0] FUNCT_MFHI  = 6'h10;
    localparam logic [5:0] FUNCT_MTHI  = 6'h11;
    localparam logic [5:0] FUNCT_MFLO  = 6'h12;
    localparam logic [5:0] FUNCT_MTLO  = 6'h13;
    localparam logic [5:0] FUNCT_MULT  = 6'h18;
    localparam logic [5:0] FUNCT_MULTU = 6'h19;
    localparam logic [5:0] FUNCT_DIV   = 6'h1A;
    localparam logic [5:0] FUNCT_DIVU  = 6'h1B;

    localparam int CNT_W = 4;

    // Multi-cycle ops (mult/multu/div/divu) occupy encodings 0..3.
    function automatic logic md_is_long(input logic [2:0] op);
        return (op[2] == 1'b0);
    endfunction

    function automatic logic md_op_valid(input logic [2:0] op);
        return (op <= 3'd5);
    endfunction

endpackage

// File: rtl/md_unit_sequencer_compute.sv
// Combinational 32x32 product / quotient / remainder for the MD unit, plus a
// divide-by-zero flag that is only raised for div/divu.
module md_compute
    import md_unit_sequencer_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] res_hi,
    output logic [31:0] res_lo,
    output logic        div_by_zero
);

    logic [63:0] prod_sgn_s;
    logic [63:0] prod_uns_s;
    logic [31:0] abs_a_s;
    logic [31:0] abs_b_s;
    logic [31:0] sdiv_s;
    logic [31:0] udiv_s;
    logic [31:0] mag_q_s;
    logic [31:0] mag_r_s;
    logic [31:0] uq_s;
    logic [31:0] ur_s;
    logic        b_zero_s;
    logic        neg_q_s;

    // Signed division runs on magnitudes; 0x80000000 / -1 falls out as 0x80000000 rem 0.
    always_comb begin
        b_zero_s   = (b == 32'd0);
        prod_sgn_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
        prod_uns_s = {32'd0, a} * {32'd0, b};
        abs_a_s    = a[31] ? (32'd0 - a) : a;
        abs_b_s    = b[31] ? (32'd0 - b) : b;
        sdiv_s     = b_zero_s ? 32'd1 : abs_b_s;
        udiv_s     = b_zero_s ? 32'd1 : b;
        mag_q_s    = abs_a_s / sdiv_s;
        mag_r_s    = abs_a_s % sdiv_s;
        uq_s       = a / udiv_s;
        ur_s       = a % udiv_s;
        neg_q_s    = a[31] ^ b[31];
        res_hi      = 32'd0;
        res_lo      = 32'd0;
        div_by_zero = 1'b0;
        case (md_op_e'(op))
            MD_MULT: begin
                res_hi = prod_sgn_s[63:32];
                res_lo = prod_sgn_s[31:0];
            end
            MD_MULTU: begin
                res_hi = prod_uns_s[63:32];
                res_lo = prod_uns_s[31:0];
            end
            MD_DIV: begin
                res_lo      = neg_q_s ? (32'd0 - mag_q_s) : mag_q_s;
                res_hi      = a[31] ? (32'd0 - mag_r_s) : mag_r_s;
                div_by_zero = b_zero_s;
            end
            MD_DIVU: begin
                res_lo      = uq_s;
                res_hi      = ur_s;
                div_by_zero = b_zero_s;
            end
            default: begin
                res_hi      = 32'd0;
                res_lo      = 32'd0;
                div_by_zero = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/md_unit_sequencer.sv
// E-stage multiply/divide unit: HI/LO registers, fixed-length busy window and
// the stall request that holds HI/LO consumers in D until the result commits.
module md_unit_sequencer
    import md_unit_sequencer_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        kill,
    input  logic        d_uses_md,
    output logic        busy,
    output logic        stall_req,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [CNT_W-1:0] MULT_N = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_N  = CNT_W'(DIV_CYCLES);

    md_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      pend_hi_q, pend_hi_d;
    logic [31:0]      pend_lo_q, pend_lo_d;
    logic             pend_dz_q, pend_dz_d;
    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;
    logic             busy_q, busy_d;

    logic [31:0] res_hi_s;
    logic [31:0] res_lo_s;
    logic        res_dz_s;
    logic        issue_s;
    logic        long_issue_s;
    logic        commit_s;

    md_compute u_compute (
        .op          (op),
        .a           (a),
        .b           (b),
        .res_hi      (res_hi_s),
        .res_lo      (res_lo_s),
        .div_by_zero (res_dz_s)
    );

    assign issue_s      = start & ~kill & ~busy_q & md_op_valid(op);
    assign long_issue_s = issue_s & md_is_long(op);
    assign commit_s     = (state_q == ST_BUSY) && (cnt_q == {{(CNT_W-1){1'b0}}, 1'b1});

    // State, counter, pending result and architectural HI/LO registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            pend_hi_q <= 32'd0;
            pend_lo_q <= 32'd0;
            pend_dz_q <= 1'b0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            pend_dz_q <= pend_dz_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            busy_q    <= busy_d;
        end
    end

    // Next-state: a long op loads its window length, each busy cycle counts down.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (long_issue_s) begin
                    state_d = ST_BUSY;
                    cnt_d   = (op[1] == 1'b0) ? MULT_N : DIV_N;
                end else begin
                    state_d = ST_IDLE;
                    cnt_d   = cnt_q;
                end
            end
            ST_BUSY: begin
                cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
                if (commit_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_BUSY;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs/datapath: capture result at issue, commit on the last busy edge,
    // and handle the single-cycle mthi/mtlo moves. A divide by zero leaves HI/LO alone.
    always_comb begin
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        pend_dz_d = pend_dz_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        if (long_issue_s) begin
            pend_hi_d = res_hi_s;
            pend_lo_d = res_lo_s;
            pend_dz_d = res_dz_s;
        end else begin
            pend_hi_d = pend_hi_q;
            pend_lo_d = pend_lo_q;
            pend_dz_d = pend_dz_q;
        end
        if (commit_s && !pend_dz_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
        end else if (issue_s && (op == MD_MTHI)) begin
            hi_d = a;
        end else if (issue_s && (op == MD_MTLO)) begin
            lo_d = a;
        end else begin
            hi_d = hi_q;
            lo_d = lo_q;
        end
        busy_d = (state_d == ST_BUSY);
    end

    assign busy      = busy_q;
    assign hi        = hi_q;
    assign lo        = lo_q;
    assign stall_req = d_uses_md & (busy_q | (start & ~kill & md_is_long(op)));

endmodule

// File: tb/tb_md_unit_sequencer.sv
// Self-checking bench for md_unit_sequencer: directed scenarios plus random
// traffic compared against a cycle-count model of the HI/LO unit.
module tb_md_unit_sequencer;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        kill;
    logic        d_uses_md;
    logic        busy;
    logic        stall_req;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] m_hi, m_lo, m_phi, m_plo;
    bit          m_pdz;
    int          m_left;
    logic        exp_stall, act_stall;

    always #5 clk = ~clk;

    md_unit_sequencer #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .a         (a),
        .b         (b),
        .kill      (kill),
        .d_uses_md (d_uses_md),
        .busy      (busy),
        .stall_req (stall_req),
        .hi        (hi),
        .lo        (lo)
    );

    // Reference arithmetic from 64-bit integer math.
    task automatic ref_compute(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                               output logic [31:0] rh, output logic [31:0] rl, output bit dz);
        longint sx, sy, p, q, r;
        longint unsigned pu;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        dz = 1'b0; rh = 32'd0; rl = 32'd0;
        case (o)
            3'd0: begin p = sx * sy; rh = p[63:32]; rl = p[31:0]; end
            3'd1: begin pu = {32'd0, x} * {32'd0, y}; rh = pu[63:32]; rl = pu[31:0]; end
            3'd2: if (y == 32'd0) dz = 1'b1;
                  else begin q = sx / sy; r = sx % sy; rl = q[31:0]; rh = r[31:0]; end
            3'd3: if (y == 32'd0) dz = 1'b1;
                  else begin rl = x / y; rh = x % y; end
            default: dz = 1'b0;
        endcase
    endtask

    task automatic model_clear();
        m_hi = 32'd0; m_lo = 32'd0; m_phi = 32'd0; m_plo = 32'd0; m_pdz = 1'b0; m_left = 0;
    endtask

    task automatic model_edge();
        if (m_left > 0) begin
            m_left--;
            if (m_left == 0 && !m_pdz) begin m_hi = m_phi; m_lo = m_plo; end
        end else if (start && !kill) begin
            if (op < 3'd4) begin
                ref_compute(op, a, b, m_phi, m_plo, m_pdz);
                m_left = (op < 3'd2) ? MULT_N : DIV_N;
            end else if (op == 3'd4) m_hi = a;
            else if (op == 3'd5) m_lo = a;
        end
    endtask

    // Drive one cycle of inputs, sample stall_req mid-cycle, then step past the edge.
    task automatic step(input logic s, input logic [2:0] o, input logic [31:0] aa,
                        input logic [31:0] bb, input logic k, input logic du);
        start = s; op = o; a = aa; b = bb; kill = k; d_uses_md = du;
        #1;
        act_stall = stall_req;
        exp_stall = du && ((m_left > 0) || (s && !k && (o < 3'd4)));
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; op = 3'd0; a = 32'd0; b = 32'd0; kill = 1'b0; d_uses_md = 1'b1;
        #2;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++; if (hi !== 32'd0) begin n_fail++; $display("FAIL reset_hi: got %h expected 0", hi); end
        n_checks++; if (lo !== 32'd0) begin n_fail++; $display("FAIL reset_lo: got %h expected 0", lo); end
        n_checks++; if (stall_req !== 1'b0) begin n_fail++; $display("FAIL reset_stall_idle: got %b expected 0", stall_req); end
        start = 1'b1;
        #1;
        n_checks++; if (stall_req !== 1'b1) begin n_fail++; $display("FAIL reset_stall_comb: got %b expected 1", stall_req); end
        start = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
        model_clear();
    endtask

    // Issue one long op and walk its whole busy window with a consumer in D.
    task automatic test_long_op(input string name, input logic [2:0] o, input logic [31:0] aa,
                                input logic [31:0] bb, input int n, input logic [31:0] eh,
                                input logic [31:0] el, input bit writes);
        logic [31:0] h0, l0, want_h, want_l;
        h0 = m_hi; l0 = m_lo;
        want_h = writes ? eh : h0;
        want_l = writes ? el : l0;
        for (int k = 0; k <= n; k++) begin
            step(k == 0, o, aa, bb, 1'b0, 1'b1);
            n_checks++; if (act_stall !== 1'b1) begin n_fail++; $display("FAIL %s_stall c%0d: got %b expected 1", name, k, act_stall); end
            n_checks++; if (busy !== (k < n)) begin n_fail++; $display("FAIL %s_busy c%0d: got %b expected %b", name, k + 1, busy, (k < n)); end
            if (k < n) begin
                n_checks++; if (hi !== h0 || lo !== l0) begin n_fail++; $display("FAIL %s_early c%0d: got %h_%h expected %h_%h", name, k + 1, hi, lo, h0, l0); end
            end else begin
                n_checks++; if (hi !== want_h) begin n_fail++; $display("FAIL %s_hi: got %h expected %h", name, hi, want_h); end
                n_checks++; if (lo !== want_l) begin n_fail++; $display("FAIL %s_lo: got %h expected %h", name, lo, want_l); end
            end
        end
        step(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b1);
        n_checks++; if (act_stall !== 1'b0) begin n_fail++; $display("FAIL %s_stall_after: got %b expected 0", name, act_stall); end
    endtask

    task automatic test_moves_and_kill();
        logic [31:0] l0;
        step(1'b1, 3'd4, 32'h12345678, 32'd0, 1'b0, 1'b0);
        n_checks++; if (hi !== 32'h12345678) begin n_fail++; $display("FAIL mthi: got %h expected 12345678", hi); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mthi_busy: got %b expected 0", busy); end
        l0 = m_lo;
        step(1'b1, 3'd5, 32'hCAFEF00D, 32'd0, 1'b1, 1'b0);
        n_checks++; if (lo !== l0) begin n_fail++; $display("FAIL mtlo_killed: got %h expected %h", lo, l0); end
        step(1'b1, 3'd5, 32'hA5A5A5A5, 32'd0, 1'b0, 1'b0);
        n_checks++; if (lo !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL mtlo: got %h expected a5a5a5a5", lo); end
        step(1'b1, 3'd7, 32'h0BADBEEF, 32'd0, 1'b0, 1'b1);
        n_checks++; if (hi !== 32'h12345678 || lo !== 32'hA5A5A5A5 || busy !== 1'b0 || act_stall !== 1'b0) begin
            n_fail++; $display("FAIL reserved_op: got hi=%h lo=%h busy=%b stall=%b", hi, lo, busy, act_stall); end
        step(1'b1, 3'd0, 32'd7, 32'd9, 1'b1, 1'b1);
        n_checks++; if (act_stall !== 1'b0) begin n_fail++; $display("FAIL kill_issue_stall: got %b expected 0", act_stall); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL kill_issue_busy: got %b expected 0", busy); end
        step(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        n_checks++; if (busy !== 1'b0 || hi !== 32'h12345678) begin n_fail++; $display("FAIL kill_issue_after: got busy=%b hi=%h expected 0/12345678", busy, hi); end
    endtask

    task automatic test_kill_while_busy();
        for (int k = 0; k <= DIV_N; k++) begin
            step(k == 0, 3'd2, 32'd100, 32'd7, (k == 2), 1'b0);
            n_checks++; if (busy !== (k < DIV_N)) begin n_fail++; $display("FAIL kwb_busy c%0d: got %b expected %b", k + 1, busy, (k < DIV_N)); end
        end
        n_checks++; if (lo !== 32'd14 || hi !== 32'd2) begin n_fail++; $display("FAIL kwb_result: got %h_%h expected 00000002_0000000e", hi, lo); end
    endtask

    task automatic test_reset_midop();
        step(1'b1, 3'd4, 32'hDEADBEEF, 32'd0, 1'b0, 1'b0);
        step(1'b1, 3'd5, 32'h13572468, 32'd0, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) step(k == 0, 3'd0, 32'd11, 32'd13, 1'b0, 1'b0);
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rmid_busy_before: got %b expected 1", busy); end
        reset = 1'b1;
        #1;
        n_checks++; if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
            n_fail++; $display("FAIL rmid_async: got busy=%b hi=%h lo=%h expected 0/0/0", busy, hi, lo); end
        @(posedge clk); #1;
        reset = 1'b0;
        model_clear();
        test_long_op("mult_after_reset", 3'd0, 32'd6, 32'hFFFFFFF9, MULT_N, 32'hFFFFFFFF, 32'hFFFFFFD6, 1'b1);
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'h80000000;
            2: return 32'hFFFFFFFF;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 2) == 0, 3'($urandom_range(0, 7)), pick_operand(), pick_operand(),
                 $urandom_range(0, 4) == 0, 1'($urandom_range(0, 1)));
            n_checks++; if (act_stall !== exp_stall) begin n_fail++; $display("FAIL rnd_stall i%0d: got %b expected %b", i, act_stall, exp_stall); end
            n_checks++; if (busy !== (m_left > 0)) begin n_fail++; $display("FAIL rnd_busy i%0d: got %b expected %b", i, busy, (m_left > 0)); end
            n_checks++; if (hi !== m_hi) begin n_fail++; $display("FAIL rnd_hi i%0d: got %h expected %h", i, hi, m_hi); end
            n_checks++; if (lo !== m_lo) begin n_fail++; $display("FAIL rnd_lo i%0d: got %h expected %h", i, lo, m_lo); end
        end
    endtask

    initial begin
        test_reset();
        test_long_op("mult", 3'd0, 32'hFFFFFFFE, 32'd3, MULT_N, 32'hFFFFFFFF, 32'hFFFFFFFA, 1'b1);
        test_long_op("multu", 3'd1, 32'hFFFFFFFF, 32'd2, MULT_N, 32'h00000001, 32'hFFFFFFFE, 1'b1);
        test_long_op("div", 3'd2, 32'hFFFFFFF9, 32'd2, DIV_N, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b1);
        test_long_op("divu_zero", 3'd3, 32'h00001234, 32'd0, DIV_N, 32'd0, 32'd0, 1'b0);
        test_long_op("div_ovf", 3'd2, 32'h80000000, 32'hFFFFFFFF, DIV_N, 32'd0, 32'h80000000, 1'b1);
        test_long_op("divu", 3'd3, 32'hFFFFFFFF, 32'd10, DIV_N, 32'd5, 32'h19999999, 1'b1);
        test_moves_and_kill();
        test_kill_while_busy();
        test_reset_midop();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
